// File: rtl/lcd_text_writer.sv
// HD44780-style text writer: rewrites the selected display lines from a flat
// character buffer, driving the LCD bus directly in 4-bit or 8-bit mode.
module lcd_text_writer #(
  parameter int NUM_LINES = 2,
  parameter int LINE_LEN  = 16,
  parameter int BUS_W     = 4,
  parameter int E_HIGH    = 2,
  parameter int WAIT_CYC  = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            start,
  input  logic [NUM_LINES-1:0]            line_mask,
  input  logic [8*LINE_LEN*NUM_LINES-1:0] text,
  output logic                            busy,
  output logic                            done,
  output logic [BUS_W-1:0]                LCD_D,
  output logic                            LCD_E,
  output logic                            LCD_RS,
  output logic                            LCD_RW,
  output logic [2:0]                      state_dbg
);

  localparam int TW = 8 * LINE_LEN * NUM_LINES;
  localparam int CW = $clog2(LINE_LEN + 1);
  localparam int EW = (E_HIGH < 2) ? 1 : $clog2(E_HIGH);
  localparam int WW = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC);

  // Selecting the next byte happens on entry to SETUP, so it has no cycle of its own.
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LINE_SEL = 3'd1;
  localparam logic [2:0] S_SETUP    = 3'd2;
  localparam logic [2:0] S_E_HI     = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;
  localparam logic [2:0] S_WAIT     = 3'd5;

  logic [2:0]           state;
  logic [NUM_LINES-1:0] rem_mask;
  logic [1:0]           line_idx;
  logic [CW-1:0]        char_cnt;
  logic                 nib;
  logic [EW-1:0]        e_cnt;
  logic [WW-1:0]        w_cnt;
  logic [TW-1:0]        text_q;

  logic [1:0]       low_bit;
  logic [1:0]       ld_line;
  logic [CW-1:0]    ld_char;
  logic             ld_nib;
  logic [6:0]       base7;
  logic [TW-1:0]    shifted;
  logic [7:0]       ld_byte;
  logic             ld_rs;
  logic [BUS_W-1:0] ld_bus;
  logic             byte_last;
  logic             line_end;
  logic             adv;

  assign LCD_RW    = 1'b0;
  assign state_dbg = state;

  // ld_char: 0 selects the set-address command, c+1 selects character c.
  always_comb begin
    low_bit = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (rem_mask[i]) low_bit = 2'(i);
    end
    ld_line = line_idx;
    ld_char = char_cnt + CW'(1);
    ld_nib  = 1'b0;
    if (state == S_LINE_SEL) begin
      ld_line = low_bit;
      ld_char = '0;
    end else if (state == S_HOLD && BUS_W == 4 && !nib) begin
      ld_char = char_cnt;
      ld_nib  = 1'b1;
    end
    case (ld_line)
      2'd0:    base7 = 7'h00;
      2'd1:    base7 = 7'h40;
      2'd2:    base7 = 7'(LINE_LEN);
      default: base7 = 7'(64 + LINE_LEN);
    endcase
    shifted = text_q >> (8 * (LINE_LEN * (NUM_LINES - int'(ld_line)) - int'(ld_char)));
    ld_byte = (ld_char == '0) ? {1'b1, base7} : shifted[7:0];
    ld_rs   = (ld_char != '0);
    if (BUS_W == 8) ld_bus = BUS_W'(ld_byte);
    else            ld_bus = BUS_W'(ld_nib ? ld_byte[3:0] : ld_byte[7:4]);
  end

  assign byte_last = (BUS_W == 8) || nib;
  assign line_end  = (char_cnt == CW'(LINE_LEN));
  assign adv = (state == S_HOLD && byte_last && WAIT_CYC == 0) ||
               (state == S_WAIT && w_cnt == WW'(WAIT_CYC - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      LCD_D    <= '0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      rem_mask <= '0;
      line_idx <= '0;
      char_cnt <= '0;
      nib      <= 1'b0;
      e_cnt    <= '0;
      w_cnt    <= '0;
      text_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            text_q <= text;
            if (line_mask == '0) begin
              done <= 1'b1;
            end else begin
              rem_mask <= line_mask;
              busy     <= 1'b1;
              state    <= S_LINE_SEL;
            end
          end
        end
        S_LINE_SEL: begin
          rem_mask <= rem_mask & ~(NUM_LINES'(1) << low_bit);
          line_idx <= low_bit;
          char_cnt <= '0;
          nib      <= 1'b0;
          LCD_D    <= ld_bus;
          LCD_RS   <= ld_rs;
          state    <= S_SETUP;
        end
        S_SETUP: begin
          LCD_E <= 1'b1;
          e_cnt <= '0;
          state <= S_E_HI;
        end
        S_E_HI: begin
          if (e_cnt == EW'(E_HIGH - 1)) begin
            LCD_E <= 1'b0;
            state <= S_HOLD;
          end else begin
            e_cnt <= e_cnt + EW'(1);
          end
        end
        S_HOLD: begin
          if (!byte_last) begin
            nib   <= 1'b1;
            LCD_D <= ld_bus;
            state <= S_SETUP;
          end else begin
            w_cnt <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: w_cnt <= w_cnt + WW'(1);
        default: state <= S_IDLE;
      endcase
      // End of a byte's wait: next character, next line, or finish.
      if (adv) begin
        if (line_end) begin
          if (rem_mask == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_LINE_SEL;
          end
        end else begin
          char_cnt <= ld_char;
          nib      <= 1'b0;
          LCD_D    <= ld_bus;
          LCD_RS   <= ld_rs;
          state    <= S_SETUP;
        end
      end
    end
  end

endmodule
